micro_sequencer: RTL

//  Parametrised T-state sequencer with a loadable microcode store. Supersedes the fixed 3-bit
//  T-state counter plus hardwired decode: counts T-states, looks up the microinstruction for
//  {opcode, T}, honours RT and a stall input, and counts retired instructions.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/ucode_store.sv | 37 +++
 rtl/micro_sequencer.sv | 100 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: width helpers, default microinstruction format, control-bit map.
// Latency: n/a (types, constants and functions only).
// Backpressure: n/a.
package cpu_pkg;

  // Default microinstruction format.
  localparam int DEF_UINSTR_W = 16;
  localparam int DEF_RT_BIT   = 0;

  // All-zero microinstruction: asserts no control line.
  localparam logic [DEF_UINSTR_W-1:0] NOP_UINSTR = '0;

  // Control-bit positions inside a microinstruction, as decoded by control.
  localparam int CB_RT      = DEF_RT_BIT;
  localparam int CB_PC_INC  = 1;
  localparam int CB_PC_OUT  = 2;
  localparam int CB_MAR_IN  = 3;
  localparam int CB_MEM_OUT = 4;
  localparam int CB_MEM_IN  = 5;
  localparam int CB_IR_IN   = 6;
  localparam int CB_ACC_IN  = 7;
  localparam int CB_ACC_OUT = 8;
  localparam int CB_ALU_SUB = 9;
  localparam int CB_ALU_OUT = 10;
  localparam int CB_OUT_IN  = 11;
  localparam int CB_HALT    = 15;

  // Width of the T-state counter; kept at least 1 so the port never collapses.
  function automatic int t_width(input int tstates);
    return (tstates > 1) ? $clog2(tstates) : 1;
  endfunction

  // Width of a microcode store address {opcode, T}.
  function automatic int addr_width(input int opcode_w, input int tstates);
    return opcode_w + t_width(tstates);
  endfunction

endpackage

// File: rtl/ucode_store.sv
// Microcode store: one synchronous write port, one asynchronous read port.
// Latency: write visible on read port after the write edge; read is zero-latency.
// Backpressure: none, a write is accepted every cycle we is high.
//
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  AW-bit write address
//   wdata  in  WIDTH-bit write data
//   raddr  in  AW-bit read address
//   rdata  out WIDTH-bit read data (combinational)
module ucode_store #(
  parameter int AW    = 11,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  // Contents are deliberately not reset: microcode is preloaded by software.
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// T-state sequencer driving a loadable microcode store; counts retired instructions.
// Latency: uinstr is combinational from T/opcode; T and instr_count update each edge.
// Backpressure: stall holds T (and suppresses retirement) for as long as it is high.
//
// Ports:
//   clk          in  clock, all state on rising edge
//   reset_bar    in  synchronous active-low reset (store writes still accepted)
//   opcode       in  current opcode from IR
//   stall        in  hold current T-state
//   ucode_we     in  microcode store write enable
//   ucode_addr   in  write address {opcode, T}
//   ucode_wdata  in  write data
//   T            out current T-state
//   uinstr       out microinstruction for this T-state, NOP while in reset
//   fetch        out high while T is one of the shared fetch steps
//   instr_done   out high in the last, unstalled T-state of an instruction
//   instr_count  out instructions retired since reset (wrapping)
module micro_sequencer
  import cpu_pkg::*;
#(
  parameter int TSTATES     = 8,
  parameter int OPCODE_W    = 8,
  parameter int UINSTR_W    = DEF_UINSTR_W,
  parameter int RT_BIT      = DEF_RT_BIT,
  parameter int FETCH_STEPS = 2,
  parameter int COUNT_W     = 16,
  localparam int T_W        = t_width(TSTATES),
  localparam int ADDR_W     = addr_width(OPCODE_W, TSTATES)
) (
  input  logic                clk,
  input  logic                reset_bar,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                stall,
  input  logic                ucode_we,
  input  logic [ADDR_W-1:0]   ucode_addr,
  input  logic [UINSTR_W-1:0] ucode_wdata,
  output logic [T_W-1:0]      T,
  output logic [UINSTR_W-1:0] uinstr,
  output logic                fetch,
  output logic                instr_done,
  output logic [COUNT_W-1:0]  instr_count
);

  localparam logic [T_W-1:0] FETCH_T = T_W'(FETCH_STEPS);
  localparam logic [T_W-1:0] LAST_T  = T_W'(TSTATES - 1);

  logic [T_W-1:0]      t_q;
  logic [T_W-1:0]      t_nxt;
  logic [COUNT_W-1:0]  count_q;
  logic [ADDR_W-1:0]   rd_addr;
  logic [UINSTR_W-1:0] store_rdata;
  logic                end_step;

  // Fetch steps are opcode-independent, so they all read from row 0.
  assign fetch   = (t_q < FETCH_T);
  assign rd_addr = fetch ? {OPCODE_W'(0), t_q} : {opcode, t_q};

  ucode_store #(
    .AW    (ADDR_W),
    .WIDTH (UINSTR_W)
  ) u_store (
    .clk   (clk),
    .we    (ucode_we),
    .waddr (ucode_addr),
    .wdata (ucode_wdata),
    .raddr (rd_addr),
    .rdata (store_rdata)
  );

  // An instruction ends either on an explicit RT or at the last T-state.
  assign end_step = store_rdata[RT_BIT] | (t_q == LAST_T);

  always_comb begin
    t_nxt = t_q;
    if (stall) begin
      t_nxt = t_q;
    end else if (end_step) begin
      t_nxt = '0;
    end else begin
      t_nxt = t_q + T_W'(1);
    end
  end

  assign instr_done = reset_bar & ~stall & end_step;

  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      t_q     <= '0;
      count_q <= '0;
    end else begin
      t_q     <= t_nxt;
      count_q <= count_q + {{(COUNT_W-1){1'b0}}, instr_done};
    end
  end

  assign T           = t_q;
  assign uinstr      = reset_bar ? store_rdata : UINSTR_W'(NOP_UINSTR);
  assign instr_count = count_q;

endmodule
